// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: redirect/stall controls and the returned instruction word go in,
// and the PC, the decoded-word handoff and the status flags come out.
interface fetch_unit_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] instr_in;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic        instr_valid;
  logic        halted;
  logic        misaligned;
  logic [31:0] retired_count;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target, instr_in,
    input  pc, pc_plus4, instr, instr_valid, halted, misaligned, retired_count
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target, instr_in,
    output pc, pc_plus4, instr, instr_valid, halted, misaligned, retired_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Program counter and fetch control: sequences BOOT -> RUN -> HALT, selects the next PC
// and stops the core for good on a bad fetch or a misaligned redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 8,
  parameter logic [31:0] ERR_INSTR  = 32'hDEAD_BEEF
) (
  input logic           clk,
  input logic           reset,
  fetch_unit_if.slave   bus
);
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;
  logic        halted_q, halted_d;
  logic        mis_q, mis_d;

  logic [31:0] pc_plus4_s;
  logic        fault_s;
  logic        redirect_s;
  logic [31:0] target_s;
  logic        bad_target_s;

  // fault/redirect decode and next-state selection
  always_comb begin
    pc_plus4_s   = pc_q + 32'd4;
    fault_s      = (pc_q[31:2] >= 30'(IMEM_WORDS)) ||
                   (bus.instr_in == ERR_INSTR) ||
                   (pc_q[1:0] != 2'b00);
    redirect_s   = bus.jump || bus.branch_taken;
    target_s     = bus.jump ? bus.jump_target : bus.branch_target;
    bad_target_s = redirect_s && (target_s[1:0] != 2'b00);

    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    halted_d = halted_q;
    mis_d    = mis_q;

    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (fault_s) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else begin
          // the current instruction commits even when its redirect target is bad
          count_d = count_q + 32'd1;
          if (bad_target_s) begin
            state_d  = HALT;
            halted_d = 1'b1;
            mis_d    = 1'b1;
          end else if (redirect_s) begin
            pc_d = target_s;
          end else begin
            pc_d = pc_plus4_s;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d  = HALT;
        halted_d = 1'b1;
      end
    endcase
  end

  // state register; reset overrides everything, including HALT
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      count_q  <= 32'd0;
      halted_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      halted_q <= halted_d;
      mis_q    <= mis_d;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pc_plus4      = pc_plus4_s;
  assign bus.instr         = bus.instr_in;
  assign bus.instr_valid   = (state_q == RUN) && !bus.stall && !fault_s;
  assign bus.halted        = halted_q;
  assign bus.misaligned    = mis_q;
  assign bus.retired_count = count_q;
endmodule
